// File: rtl/signed_peak_tracker.sv
// signed_peak_tracker: per-window signed max/min/tie tracker with valid/ready handshakes on both sides.
// Optional macro PEAK_TRACKER_IDX_EN adds max_idx/min_idx (first-occurrence in-window positions).
//
// state | meaning
// IDLE  | no sample in the current window
// ACC   | 1..WINDOW-1 samples accumulated
// DONE  | window result presented on the outputs, waiting for out_ready

module signed_peak_tracker #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] max_out,
    output logic signed [WIDTH-1:0] min_out,
    output logic [7:0]              max_ties
`ifdef PEAK_TRACKER_IDX_EN
    ,
    output logic [7:0]              max_idx,
    output logic [7:0]              min_idx
`endif
);

    localparam int CW = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]           count_q, count_d;
    logic signed [WIDTH-1:0] cur_max_q, cur_max_d;
    logic signed [WIDTH-1:0] cur_min_q, cur_min_d;
    logic [7:0]              cur_ties_q, cur_ties_d;
    logic signed [WIDTH-1:0] del_max_q, del_max_d;
    logic signed [WIDTH-1:0] del_min_q, del_min_d;
    logic [7:0]              del_ties_q, del_ties_d;
`ifdef PEAK_TRACKER_IDX_EN
    logic [7:0]              cur_max_idx_q, cur_max_idx_d;
    logic [7:0]              cur_min_idx_q, cur_min_idx_d;
    logic [7:0]              del_max_idx_q, del_max_idx_d;
    logic [7:0]              del_min_idx_q, del_min_idx_d;
`endif

    logic                    accept;
    logic                    last_sample;
    logic signed [WIDTH:0]   diff_max;
    logic signed [WIDTH:0]   diff_min;
    logic                    gt_max;
    logic                    eq_max;
    logic                    lt_min;

    assign in_ready    = (state_q != DONE);
    assign out_valid   = (state_q == DONE);
    assign accept      = in_valid && in_ready;
    assign last_sample = (count_q == CW'(WINDOW - 1));

    // One extra bit keeps e.g. 127 - (-128) from wrapping into a negative result.
    assign diff_max = {in_data[WIDTH-1], in_data} - {cur_max_q[WIDTH-1], cur_max_q};
    assign diff_min = {in_data[WIDTH-1], in_data} - {cur_min_q[WIDTH-1], cur_min_q};
    assign gt_max   = (diff_max > 0);
    assign eq_max   = (in_data == cur_max_q);
    assign lt_min   = (diff_min < 0);

    // While presenting, show the live window result; otherwise the last one actually consumed.
    assign max_out  = out_valid ? cur_max_q  : del_max_q;
    assign min_out  = out_valid ? cur_min_q  : del_min_q;
    assign max_ties = out_valid ? cur_ties_q : del_ties_q;
`ifdef PEAK_TRACKER_IDX_EN
    assign max_idx  = out_valid ? cur_max_idx_q : del_max_idx_q;
    assign min_idx  = out_valid ? cur_min_idx_q : del_min_idx_q;
`endif

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        cur_max_d  = cur_max_q;
        cur_min_d  = cur_min_q;
        cur_ties_d = cur_ties_q;
        del_max_d  = del_max_q;
        del_min_d  = del_min_q;
        del_ties_d = del_ties_q;
`ifdef PEAK_TRACKER_IDX_EN
        cur_max_idx_d = cur_max_idx_q;
        cur_min_idx_d = cur_min_idx_q;
        del_max_idx_d = del_max_idx_q;
        del_min_idx_d = del_min_idx_q;
`endif
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cur_max_d  = in_data;
                        cur_min_d  = in_data;
                        cur_ties_d = 8'd1;
                        count_d    = CW'(1);
`ifdef PEAK_TRACKER_IDX_EN
                        cur_max_idx_d = 8'd0;
                        cur_min_idx_d = 8'd0;
`endif
                        state_d    = ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        if (gt_max) begin
                            cur_max_d  = in_data;
                            cur_ties_d = 8'd1;
`ifdef PEAK_TRACKER_IDX_EN
                            cur_max_idx_d = 8'(count_q);
`endif
                        end else if (eq_max) begin
                            cur_ties_d = cur_ties_q + 8'd1;
                        end
                        if (lt_min) begin
                            cur_min_d = in_data;
`ifdef PEAK_TRACKER_IDX_EN
                            cur_min_idx_d = 8'(count_q);
`endif
                        end
                        count_d = count_q + CW'(1);
                        if (last_sample) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        del_max_d  = cur_max_q;
                        del_min_d  = cur_min_q;
                        del_ties_d = cur_ties_q;
`ifdef PEAK_TRACKER_IDX_EN
                        del_max_idx_d = cur_max_idx_q;
                        del_min_idx_d = cur_min_idx_q;
`endif
                        count_d    = '0;
                        state_d    = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            count_q    <= '0;
            cur_max_q  <= '0;
            cur_min_q  <= '0;
            cur_ties_q <= '0;
            del_max_q  <= '0;
            del_min_q  <= '0;
            del_ties_q <= '0;
`ifdef PEAK_TRACKER_IDX_EN
            cur_max_idx_q <= '0;
            cur_min_idx_q <= '0;
            del_max_idx_q <= '0;
            del_min_idx_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            cur_max_q  <= cur_max_d;
            cur_min_q  <= cur_min_d;
            cur_ties_q <= cur_ties_d;
            del_max_q  <= del_max_d;
            del_min_q  <= del_min_d;
            del_ties_q <= del_ties_d;
`ifdef PEAK_TRACKER_IDX_EN
            cur_max_idx_q <= cur_max_idx_d;
            cur_min_idx_q <= cur_min_idx_d;
            del_max_idx_q <= del_max_idx_d;
            del_min_idx_q <= del_min_idx_d;
`endif
        end
    end

endmodule

// File: doc/signed_peak_tracker.md
SIGNED_PEAK_TRACKER -- requirements
Module: signed_peak_tracker

Interface
REQ-001 SHALL have parameter WIDTH, default 8, sample width in bits (signed two's complement).
REQ-002 SHALL have parameter WINDOW, default 16, samples per window (range 2..256).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port clear, input, 1, synchronous abort of the current window.
REQ-006 SHALL have port in_valid, input, 1, sample offered.
REQ-007 SHALL have port in_data, input, WIDTH, signed sample.
REQ-008 SHALL have port in_ready, output, 1, sample accepted when in_valid && in_ready.
REQ-009 SHALL have port out_valid, output, 1, window result available.
REQ-010 SHALL have port out_ready, input, 1, result consumed when out_valid && out_ready.
REQ-011 SHALL have port max_out, output, WIDTH, signed maximum of the window.
REQ-012 SHALL have port min_out, output, WIDTH, signed minimum of the window.
REQ-013 SHALL have port max_ties, output, 8, number of accepted samples equal to the final maximum, including the first.

Function
REQ-014 SHALL implement FSM with states IDLE (no sample in window), ACC (1..WINDOW-1 samples), DONE (result held).
REQ-015 In IDLE, an accepted sample SHALL load max and min with the sample, set ties=1, set count=1, and go to ACC.
REQ-016 In ACC, an accepted sample SHALL be compared signed against max and min: greater than max -> max=sample, ties=1; equal to max -> ties+1; lower than min -> min=sample.
REQ-017 The greater/lower comparison SHALL use a WIDTH+1-bit signed difference so that no overflow occurs (e.g. 127 vs -128 at WIDTH=8 yields greater).
REQ-018 Acceptance of the WINDOW-th sample SHALL move to DONE; out_valid SHALL rise on the next cycle, one cycle after that acceptance.
REQ-019 in_ready SHALL be 1 in IDLE and ACC and 0 in DONE; it SHALL depend only on registered state.
REQ-020 In DONE, max_out, min_out and max_ties SHALL be stable until the handshake; the handshake SHALL return to IDLE with in_ready=1 on the next cycle.
REQ-021 Outside DONE, out_valid SHALL be 0; max_out, min_out and max_ties SHALL hold the last delivered result.
REQ-022 clear=1 SHALL discard the partial window and go to IDLE from any state, including DONE with out_valid high; the same-cycle input or output handshake SHALL be ignored; clear SHALL take priority over all events.
REQ-023 When in_valid is low in ACC, all state SHALL be held; there SHALL be no timeout.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, out_valid=0, max_out=0, min_out=0, max_ties=0, and the internal count to 0, independent of clk.
REQ-025 Reset assertion mid-window SHALL discard all accumulated samples; the first sample after release SHALL start a new window.

Configuration
REQ-026 Macro PEAK_TRACKER_IDX_EN defined: extra outputs max_idx and min_idx, each 8 bits, SHALL carry the 0-based in-window position of the first occurrence of max and min; both SHALL reset to 0 and be held like the other results.
REQ-027 Macro PEAK_TRACKER_IDX_EN undefined: these ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 WIDTH=8, WINDOW=4, samples 5, -3, 7, 2 -> out_valid one cycle after the 4th acceptance; max=7, min=-3, ties=1; with PEAK_TRACKER_IDX_EN, max_idx=2 and min_idx=1.
REQ-029 Samples 127, -128, 127, 127 -> max=127, min=-128, ties=3; no overflow misordering.
REQ-030 Result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and outputs stable throughout; out_ready=1 -> IDLE next cycle, then new samples accepted.
REQ-031 clear asserted after 2 samples, then 4 samples -1, -1, -1, -1 -> max=-1, min=-1, ties=4.
REQ-032 rst_n pulsed low mid-window with no clk edge -> outputs 0 and state IDLE immediately; a following full window produces a correct result.
